// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access sequencer:
// FSM states, R/W bit values and the per-step {start, mack, stop, r_wn} flag tuples.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_W,
    S_REG,
    S_ADDR_R,
    S_DATA_W,
    S_DATA_R,
    S_RECOVER,
    S_DONE
  } state_t;

  // REQ: byte_req raised and awaiting byte_ack; DROP: awaiting byte_ack low.
  typedef enum logic {
    PH_REQ,
    PH_DROP
  } phase_t;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  typedef struct packed {
    logic start;
    logic mack;
    logic stop;
    logic r_wn;
  } step_flags_t;

  localparam step_flags_t FLAGS_NONE    = '{start: 1'b0, mack: 1'b0, stop: 1'b0, r_wn: I2C_WR};
  localparam step_flags_t FLAGS_ADDR_W  = '{start: 1'b1, mack: 1'b0, stop: 1'b0, r_wn: I2C_WR};
  localparam step_flags_t FLAGS_REG     = '{start: 1'b0, mack: 1'b0, stop: 1'b0, r_wn: I2C_WR};
  localparam step_flags_t FLAGS_ADDR_R  = '{start: 1'b1, mack: 1'b0, stop: 1'b0, r_wn: I2C_WR};
  localparam step_flags_t FLAGS_DATA_W  = '{start: 1'b0, mack: 1'b0, stop: 1'b1, r_wn: I2C_WR};
  localparam step_flags_t FLAGS_DATA_R  = '{start: 1'b0, mack: 1'b0, stop: 1'b1, r_wn: I2C_RD};
  localparam step_flags_t FLAGS_RECOVER = '{start: 1'b0, mack: 1'b0, stop: 1'b1, r_wn: I2C_RD};

  function automatic logic is_step(input state_t s);
    return s inside {S_ADDR_W, S_REG, S_ADDR_R, S_DATA_W, S_DATA_R, S_RECOVER};
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Host-side register request bus and the byte-level bus toward i2c_byte.
// Host: master = requester, slave = sequencer. Byte: master = sequencer, slave = i2c_byte.
interface i2c_host_if;
  logic       req;
  logic       ack;
  logic       r_wn;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       nack_err;
  logic       busy;

  modport master (output req, r_wn, dev_addr, reg_addr, wr_data,
                  input  ack, rd_data, nack_err, busy);
  modport slave  (input  req, r_wn, dev_addr, reg_addr, wr_data,
                  output ack, rd_data, nack_err, busy);
endinterface

interface i2c_byte_if;
  logic       byte_req;
  logic       byte_ack;
  logic       byte_r_wn;
  logic [7:0] byte_wr_data;
  logic [7:0] byte_rd_data;
  logic       byte_start;
  logic       byte_mack;
  logic       byte_stop;
  logic       byte_acked;

  modport master (output byte_req, byte_r_wn, byte_wr_data, byte_start, byte_mack, byte_stop,
                  input  byte_ack, byte_rd_data, byte_acked);
  modport slave  (input  byte_req, byte_r_wn, byte_wr_data, byte_start, byte_mack, byte_stop,
                  output byte_ack, byte_rd_data, byte_acked);
endinterface

// File: rtl/i2c_reg_ctrl.sv
// Register-access sequencer: expands one host read/write request into the
// i2c_byte step sequence, with NACK recovery and whole-transaction retry.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int RETRIES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  i2c_host_if.slave     host,
  i2c_byte_if.master    bus
);

  localparam int CNT_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic        r_wn_q;
  logic [6:0]  dev_addr_q;
  logic [7:0]  reg_addr_q, wr_data_q;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        nacked_q, nacked_d;
  logic        nack_err_q, nack_err_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic        accept;
  logic        attempt_failed;
  step_flags_t flags;
  logic [7:0]  step_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_REQ;
      r_wn_q     <= 1'b0;
      dev_addr_q <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      nacked_q   <= 1'b0;
      nack_err_q <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rd_data_q  <= rd_data_d;
      nacked_q   <= nacked_d;
      nack_err_q <= nack_err_d;
      retry_q    <= retry_d;
      if (accept) begin
        r_wn_q     <= host.r_wn;
        dev_addr_q <= host.dev_addr;
        reg_addr_q <= host.reg_addr;
        wr_data_q  <= host.wr_data;
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    rd_data_d      = rd_data_q;
    nacked_d       = nacked_q;
    nack_err_d     = nack_err_q;
    retry_d        = retry_q;
    accept         = 1'b0;
    attempt_failed = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.req) begin
          accept  = 1'b1;
          retry_d = '0;
          state_d = S_ADDR_W;
          phase_d = PH_REQ;
        end
      end
      S_ADDR_W, S_REG, S_ADDR_R, S_DATA_W, S_DATA_R, S_RECOVER: begin
        if (phase_q == PH_REQ) begin
          if (bus.byte_ack) begin
            nacked_d = bus.byte_acked;
            if (state_q == S_DATA_R) rd_data_d = bus.byte_rd_data;
            phase_d = PH_DROP;
          end
        end else if (!bus.byte_ack) begin
          phase_d = PH_REQ;
          case (state_q)
            S_ADDR_W: state_d = nacked_q ? S_RECOVER : S_REG;
            S_REG:    state_d = nacked_q ? S_RECOVER : ((r_wn_q == I2C_RD) ? S_ADDR_R : S_DATA_W);
            S_ADDR_R: state_d = nacked_q ? S_RECOVER : S_DATA_R;
            S_DATA_W: begin
              // This step already carried STOP, so a NACK needs no recovery byte.
              if (nacked_q) attempt_failed = 1'b1;
              else begin
                state_d    = S_DONE;
                nack_err_d = 1'b0;
              end
            end
            S_DATA_R: begin
              state_d    = S_DONE;
              nack_err_d = 1'b0;
            end
            default: attempt_failed = 1'b1;
          endcase
          if (attempt_failed) begin
            if (int'(retry_q) < RETRIES) begin
              retry_d = retry_q + CNT_W'(1);
              state_d = S_ADDR_W;
            end else begin
              nack_err_d = 1'b1;
              state_d    = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!host.req) begin
          state_d = S_IDLE;
          phase_d = PH_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = PH_REQ;
      end
    endcase
  end

  // Byte-step fields derive only from state and latched request fields,
  // so they hold steady for the whole time byte_req is high.
  always_comb begin
    flags     = FLAGS_NONE;
    step_data = '0;
    case (state_q)
      S_ADDR_W:  begin flags = FLAGS_ADDR_W;  step_data = {dev_addr_q, I2C_WR}; end
      S_REG:     begin flags = FLAGS_REG;     step_data = reg_addr_q;           end
      S_ADDR_R:  begin flags = FLAGS_ADDR_R;  step_data = {dev_addr_q, I2C_RD}; end
      S_DATA_W:  begin flags = FLAGS_DATA_W;  step_data = wr_data_q;            end
      S_DATA_R:  flags = FLAGS_DATA_R;
      S_RECOVER: flags = FLAGS_RECOVER;
      default:   ;
    endcase
  end

  assign bus.byte_req     = is_step(state_q) && (phase_q == PH_REQ);
  assign bus.byte_wr_data = step_data;
  assign bus.byte_start   = flags.start;
  assign bus.byte_mack    = flags.mack;
  assign bus.byte_stop    = flags.stop;
  assign bus.byte_r_wn    = flags.r_wn;

  assign host.ack      = (state_q == S_DONE);
  assign host.busy     = (state_q != S_IDLE);
  assign host.rd_data  = rd_data_q;
  assign host.nack_err = nack_err_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: an i2c_byte stub with programmable delay/NACK, and a
// transaction-level reference model that lists the expected byte steps.
module tb_i2c_reg_ctrl;

  localparam int RETRIES = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_host_if host ();
  i2c_byte_if bus ();

  i2c_reg_ctrl #(.RETRIES(RETRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host.slave),
    .bus   (bus.master)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub programming and observation; record layout {data, start, mack, stop, r_wn}.
  int          stub_delay   = 1;
  bit          stub_rand_dl = 1'b0;
  logic [7:0]  nack_data    = 8'h00;
  int          nack_count   = 0;  // -1 = NACK every time
  int          nack_left    = 0;
  logic [7:0]  stub_rd      = 8'h00;
  logic [11:0] log_q[$];
  int          field_err    = 0;
  int          stub_timeout = 0;
  int          drop_cyc     = 0;
  bit          stub_busy    = 1'b0;

  logic [11:0] rec;
  logic        s_nack;
  bit          s_abort;
  int          s_wait, s_dl;

  function automatic logic [11:0] cur_fields();
    return {bus.byte_wr_data, bus.byte_start, bus.byte_mack, bus.byte_stop, bus.byte_r_wn};
  endfunction

  initial begin
    bus.byte_ack     = 1'b0;
    bus.byte_acked   = 1'b0;
    bus.byte_rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.byte_req && !bus.byte_ack) begin
        stub_busy = 1'b1;
        rec = cur_fields();
        log_q.push_back(rec);
        s_nack = 1'b0;
        if (!bus.byte_r_wn && bus.byte_wr_data == nack_data && nack_left != 0) begin
          s_nack = 1'b1;
          if (nack_left > 0) nack_left--;
        end else if (bus.byte_r_wn) begin
          s_nack = 1'($urandom);  // must be ignored by the sequencer
        end
        s_dl = stub_rand_dl ? int'($urandom_range(0, 3)) : stub_delay;
        s_abort = 1'b0;
        for (int i = 0; i < s_dl; i++) begin
          @(posedge clk); #1;
          if (!rst_n || !bus.byte_req) begin s_abort = 1'b1; break; end
          if (cur_fields() !== rec) field_err++;
        end
        if (!s_abort) begin
          bus.byte_acked   = s_nack;
          bus.byte_rd_data = bus.byte_r_wn ? stub_rd : 8'($urandom);
          bus.byte_ack     = 1'b1;
          s_wait = 0;
          while (bus.byte_req && s_wait < 1000) begin
            if (cur_fields() !== rec) field_err++;
            @(posedge clk); #1;
            s_wait++;
          end
          if (s_wait >= 1000) stub_timeout++;
          bus.byte_ack = 1'b0;
          drop_cyc = cyc;
        end
        stub_busy = 1'b0;
      end
    end
  end

  // A new byte_req must never rise while byte_ack was already high.
  int   proto_err = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  always @(negedge clk) begin
    if (bus.byte_req && !prev_req && prev_ack) proto_err++;
    prev_req <= bus.byte_req;
    prev_ack <= bus.byte_ack;
  end

  // Reference model: expands a request into the expected steps from the protocol rules.
  logic [11:0] exp_q[$];
  logic        exp_err;
  logic [7:0]  rd_model = 8'h00;

  task automatic build_expected(input logic rw, input logic [6:0] dev,
                                input logic [7:0] rg, input logic [7:0] wd);
    int          left;
    bit          ok;
    logic [11:0] steps[$];
    left = nack_count;
    exp_q.delete();
    exp_err = 1'b1;
    for (int a = 0; a <= RETRIES; a++) begin
      steps.delete();
      steps.push_back({dev, 1'b0, 4'b1000});
      steps.push_back({rg, 4'b0000});
      if (rw) begin
        steps.push_back({dev, 1'b1, 4'b1000});
        steps.push_back({8'h00, 4'b0011});
      end else begin
        steps.push_back({wd, 4'b0010});
      end
      ok = 1'b1;
      for (int i = 0; i < steps.size(); i++) begin
        exp_q.push_back(steps[i]);
        if (steps[i][0] == 1'b0 && steps[i][11:4] == nack_data && left != 0) begin
          if (left > 0) left--;
          ok = 1'b0;
          if (!steps[i][1]) exp_q.push_back({8'h00, 4'b0011});
          break;
        end
      end
      if (ok) begin
        exp_err = 1'b0;
        if (rw) rd_model = stub_rd;
        break;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd, input int hold);
    int n, busy_err, held_err, fe0, pe0;
    build_expected(rw, dev, rg, wd);
    nack_left = nack_count;
    log_q.delete();
    fe0 = field_err + stub_timeout;
    pe0 = proto_err;
    @(posedge clk); #1;
    host.req = 1'b1; host.r_wn = rw; host.dev_addr = dev; host.reg_addr = rg; host.wr_data = wd;
    @(posedge clk); #1;
    tests++;
    if (bus.byte_req !== 1'b1 || host.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s req_latency: byte_req=%b busy=%b, required 1 1", name, bus.byte_req, host.busy);
    end
    host.r_wn = ~rw; host.dev_addr = 7'($urandom); host.reg_addr = 8'($urandom); host.wr_data = 8'($urandom);
    n = 0; busy_err = 0;
    while (host.ack !== 1'b1 && n < 5000) begin
      if (host.busy !== 1'b1) busy_err++;
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL %s ack_timeout: ack=%b after %0d cycles, required 1", name, host.ack, n);
    end
    tests++;
    if (cyc - drop_cyc != 1) begin
      fails++;
      $display("FAIL %s done_latency: %0d cycles from byte_ack fall to ack, required 1", name, cyc - drop_cyc);
    end
    tests++;
    if (busy_err != 0) begin
      fails++;
      $display("FAIL %s busy_during: %0d cycles busy=0, required 0", name, busy_err);
    end
    tests++;
    if (host.nack_err !== exp_err || host.rd_data !== rd_model) begin
      fails++;
      $display("FAIL %s result: nack_err=%b rd_data=%h, required %b %h", name, host.nack_err, host.rd_data, exp_err, rd_model);
    end
    tests++;
    if (log_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s step_count: %0d byte steps, required %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (log_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s step%0d: {data,s,m,p,rw}=%h, required %h", name, i, log_q[i], exp_q[i]);
        end
      end
    end
    held_err = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (host.ack !== 1'b1 || bus.byte_req !== 1'b0) held_err++;
    end
    host.req = 1'b0;
    tests++;
    if (held_err != 0 || host.ack !== 1'b1) begin
      fails++;
      $display("FAIL %s ack_hold: %0d bad cycles, ack=%b at req fall, required 0 and 1", name, held_err, host.ack);
    end
    @(posedge clk); #1;
    tests++;
    if (host.ack !== 1'b0 || host.busy !== 1'b0 || host.nack_err !== exp_err || host.rd_data !== rd_model) begin
      fails++;
      $display("FAIL %s ack_release: ack=%b busy=%b nack_err=%b rd=%h, required 0 0 %b %h",
               name, host.ack, host.busy, host.nack_err, host.rd_data, exp_err, rd_model);
    end
    tests++;
    if (field_err + stub_timeout != fe0 || proto_err != pe0) begin
      fails++;
      $display("FAIL %s byte_protocol: %0d field/timeout errors, %0d req-while-ack, required 0 0",
               name, field_err + stub_timeout - fe0, proto_err - pe0);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({host.ack, host.busy, host.nack_err, host.rd_data, bus.byte_req, bus.byte_start,
         bus.byte_mack, bus.byte_stop, bus.byte_r_wn, bus.byte_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_values: ack=%b busy=%b nerr=%b rd=%h breq=%b, required all 0",
               host.ack, host.busy, host.nack_err, host.rd_data, bus.byte_req);
    end
  endtask

  task automatic test_write();
    nack_count = 0; stub_delay = 1;
    run_txn("write", 1'b0, 7'h50, 8'h12, 8'hA5, 2);
  endtask

  task automatic test_read();
    nack_count = 0; stub_delay = 2; stub_rd = 8'h5C;
    run_txn("read", 1'b1, 7'h50, 8'h34, 8'h00, 2);
  endtask

  task automatic test_nack_addr_all();
    nack_data = 8'hA0; nack_count = -1; stub_delay = 1;
    run_txn("nack_addr_all", 1'b0, 7'h50, 8'h12, 8'hA5, 1);
  endtask

  task automatic test_nack_reg_once();
    nack_data = 8'h12; nack_count = 1; stub_delay = 1;
    run_txn("nack_reg_once", 1'b0, 7'h50, 8'h12, 8'hA5, 1);
  endtask

  task automatic test_nack_data_all();
    nack_data = 8'h3C; nack_count = -1; stub_delay = 0;
    run_txn("nack_data_all", 1'b0, 7'h22, 8'h07, 8'h3C, 1);
  endtask

  task automatic test_delays();
    nack_count = 0; stub_rd = 8'h96;
    stub_delay = 0;
    run_txn("delay0_read", 1'b1, 7'h1B, 8'hF0, 8'h00, 20);
    stub_delay = 50;
    run_txn("delay50_write", 1'b0, 7'h6E, 8'h81, 8'h42, 20);
  endtask

  task automatic test_reset_mid();
    int n;
    nack_count = 0; stub_delay = 5;
    log_q.delete();
    @(posedge clk); #1;
    host.req = 1'b1; host.r_wn = 1'b1; host.dev_addr = 7'h33; host.reg_addr = 8'h44; host.wr_data = 8'h00;
    n = 0;
    while (log_q.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
    tests++;
    if (n >= 200 || log_q[1] !== {8'h44, 4'b0000}) begin
      fails++;
      $display("FAIL reset_mid_reach_reg: %0d steps seen, required the reg step", log_q.size());
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.byte_req !== 1'b0 || host.ack !== 1'b0 || host.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_async: byte_req=%b ack=%b busy=%b, required 0 0 0", bus.byte_req, host.ack, host.busy);
    end
    host.req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_model = 8'h00;
    n = 0;
    while ((stub_busy || bus.byte_ack) && n < 100) begin @(posedge clk); #1; n++; end
    test_reset();
    stub_rd = 8'hC3; stub_delay = 1;
    run_txn("after_reset", 1'b1, 7'h33, 8'h44, 8'h00, 1);
  endtask

  task automatic test_random();
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg, wd;
    stub_rand_dl = 1'b1;
    for (int t = 0; t < 24; t++) begin
      rw = 1'($urandom); dev = 7'($urandom); rg = 8'($urandom); wd = 8'($urandom);
      stub_rd = 8'($urandom);
      case ($urandom_range(0, 4))
        0: nack_data = {dev, 1'b0};
        1: nack_data = rg;
        2: nack_data = wd;
        3: nack_data = {dev, 1'b1};
        default: nack_data = 8'($urandom);
      endcase
      nack_count = ($urandom_range(0, 5) == 5) ? -1 : int'($urandom_range(0, 3));
      run_txn($sformatf("rand%0d", t), rw, dev, rg, wd, int'($urandom_range(0, 4)));
    end
    stub_rand_dl = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    host.req = 1'b0; host.r_wn = 1'b0; host.dev_addr = '0; host.reg_addr = '0; host.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_nack_addr_all();
    test_nack_reg_once();
    test_nack_data_all();
    test_delays();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
